// File: rtl/bypass_net_pkg.sv
// Shared types and constants for the operand forwarding network.
// Latency: none (types and constants only). Backpressure: not applicable.
package bypass_net_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 4;

    typedef logic [REG_AW_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    localparam int REG_ZERO = 0;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;
endpackage

// File: rtl/bypass_net_port.sv
// One read port: youngest-stage tag match, selects forwarded or register-file data.
// Latency: 0 cycles, combinational. Backpressure: raises hazard_o when the youngest producer is not ready.
module bypass_port
    import bypass_net_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 3
) (
    input  logic [DEPTH-1:0]        v_i,
    input  logic [DEPTH*REG_AW-1:0] t_i,
    input  logic [REG_AW-1:0]       rd_addr_i,
    input  logic [DATA_W-1:0]       rf_data_i,
    input  logic [DEPTH*DATA_W-1:0] stage_data_i,
    input  logic [DEPTH-1:0]        stage_rdy_i,
    output logic [DATA_W-1:0]       rd_data_o,
    output logic                    hit_o,
    output logic                    hazard_o
);
    logic found;

    // Only the youngest match is considered; an older ready copy is stale.
    always_comb begin
        rd_data_o = rf_data_i;
        hit_o     = 1'b0;
        hazard_o  = 1'b0;
        found     = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && v_i[k] && (t_i[k*REG_AW +: REG_AW] == rd_addr_i) &&
                (rd_addr_i != REG_AW'(REG_ZERO))) begin
                found = 1'b1;
                if (stage_rdy_i[k]) begin
                    rd_data_o = stage_data_i[k*DATA_W +: DATA_W];
                    hit_o     = 1'b1;
                end else begin
                    hazard_o  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/bypass_net.sv
// Forwarding network: destination-tag shift pipeline plus per-port youngest-match bypass.
// Latency: 0 cycles lookup; tags advance one stage per unfrozen cycle. Backpressure: stall_req_o on load-use.
module bypass_net
    import bypass_net_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     freeze_i,
    input  logic                     flush_i,
    input  logic                     iss_valid_i,
    input  logic [REG_AW-1:0]        iss_addr_i,
    input  logic [DEPTH*DATA_W-1:0]  stage_data_i,
    input  logic [DEPTH-1:0]         stage_rdy_i,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr_i,
    input  logic [NUM_RD*DATA_W-1:0] rf_data_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        fwd_hit_o,
    output logic                     stall_req_o,
    output logic [15:0]              fwd_cnt_o
);
    logic [DEPTH-1:0]        v_q, v_d;
    logic [DEPTH*REG_AW-1:0] t_q, t_d;
    logic [15:0]             fwd_cnt_q, fwd_cnt_d;
    logic [NUM_RD-1:0]       hazard;
    logic [16:0]             cnt_sum;

    for (genvar j = 0; j < NUM_RD; j++) begin : g_port
        bypass_port #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH)
        ) u_port (
            .v_i          (v_q),
            .t_i          (t_q),
            .rd_addr_i    (rd_addr_i[j*REG_AW +: REG_AW]),
            .rf_data_i    (rf_data_i[j*DATA_W +: DATA_W]),
            .stage_data_i (stage_data_i),
            .stage_rdy_i  (stage_rdy_i),
            .rd_data_o    (rd_data_o[j*DATA_W +: DATA_W]),
            .hit_o        (fwd_hit_o[j]),
            .hazard_o     (hazard[j])
        );
    end

    assign stall_req_o = |hazard;
    assign fwd_cnt_o   = fwd_cnt_q;

    // Flush clears stage 0 even while frozen; older stages still obey freeze.
    always_comb begin
        v_d = v_q;
        t_d = t_q;
        if (!freeze_i) begin
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k]                  = v_q[k-1];
                t_d[k*REG_AW +: REG_AW] = t_q[(k-1)*REG_AW +: REG_AW];
            end
            v_d[STG_EX]                       = iss_valid_i && (iss_addr_i != REG_AW'(REG_ZERO));
            t_d[STG_EX*REG_AW +: REG_AW]      = iss_addr_i;
        end
        if (flush_i) begin
            v_d[STG_EX] = 1'b0;
        end
    end

    always_comb begin
        cnt_sum = {1'b0, fwd_cnt_q};
        for (int j = 0; j < NUM_RD; j++) begin
            cnt_sum = cnt_sum + 17'(fwd_hit_o[j]);
        end
        fwd_cnt_d = fwd_cnt_q;
        if (!freeze_i && !stall_req_o) begin
            fwd_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            t_q       <= '0;
            fwd_cnt_q <= '0;
        end else begin
            v_q       <= v_d;
            t_q       <= t_d;
            fwd_cnt_q <= fwd_cnt_d;
        end
    end
endmodule

// File: tb/tb_bypass_net.sv
// Bench for bypass_net: directed hazard scenarios plus random traffic against a stage-list model.
module tb_bypass_net;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 2;
    localparam int DP = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           freeze_i, flush_i, iss_valid_i;
    logic [AW-1:0]  iss_addr_i;
    logic [DP*DW-1:0] stage_data_i;
    logic [DP-1:0]  stage_rdy_i;
    logic [NR*AW-1:0] rd_addr_i;
    logic [NR*DW-1:0] rf_data_i;
    logic [NR*DW-1:0] rd_data_o;
    logic [NR-1:0]  fwd_hit_o;
    logic           stall_req_o;
    logic [15:0]    fwd_cnt_o;

    bypass_net #(.DATA_W(DW), .REG_AW(AW), .NUM_RD(NR), .DEPTH(DP)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze_i     (freeze_i),
        .flush_i      (flush_i),
        .iss_valid_i  (iss_valid_i),
        .iss_addr_i   (iss_addr_i),
        .stage_data_i (stage_data_i),
        .stage_rdy_i  (stage_rdy_i),
        .rd_addr_i    (rd_addr_i),
        .rf_data_i    (rf_data_i),
        .rd_data_o    (rd_data_o),
        .fwd_hit_o    (fwd_hit_o),
        .stall_req_o  (stall_req_o),
        .fwd_cnt_o    (fwd_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: list of in-flight writers, index 0 youngest.
    bit          m_v[DP];
    int unsigned m_t[DP];
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; freeze_i = 1'b0; flush_i = 1'b0; iss_valid_i = 1'b0;
        iss_addr_i = '0; stage_data_i = '0; stage_rdy_i = '1;
        rd_addr_i = '0; rf_data_i = '0;
    endtask

    function automatic logic [DW-1:0] sdat(input int k);
        logic [DP*DW-1:0] tmp;
        tmp = stage_data_i;
        return tmp[k*DW +: DW];
    endfunction

    // Compare all outputs against the model for current inputs, then clock and update the model.
    task automatic cycle();
        bit          any_stall;
        int unsigned nhits;
        int unsigned addr;
        logic [DW-1:0] exp_d;
        bit          exp_h;
        #1;
        any_stall = 0;
        nhits = 0;
        for (int j = 0; j < NR; j++) begin
            addr  = rd_addr_i[j*AW +: AW];
            exp_d = rf_data_i[j*DW +: DW];
            exp_h = 0;
            if (addr != 0) begin
                for (int k = 0; k < DP; k++) begin
                    if (m_v[k] && m_t[k] == addr) begin
                        if (stage_rdy_i[k]) begin
                            exp_d = sdat(k);
                            exp_h = 1;
                        end else begin
                            any_stall = 1;
                        end
                        break;
                    end
                end
            end
            if (exp_h) nhits++;
            chk($sformatf("data%0d", j), 32'(rd_data_o[j*DW +: DW]), 32'(exp_d));
            chk($sformatf("hit%0d", j), 32'(fwd_hit_o[j]), 32'(exp_h));
        end
        chk("stall", 32'(stall_req_o), 32'(any_stall));
        chk("cnt", 32'(fwd_cnt_o), m_cnt);
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < DP; k++) begin m_v[k] = 0; m_t[k] = 0; end
            m_cnt = 0;
        end else begin
            if (!freeze_i && !any_stall) begin
                m_cnt = m_cnt + nhits;
                if (m_cnt > 32'hFFFF) m_cnt = 32'hFFFF;
            end
            if (!freeze_i) begin
                for (int k = DP - 1; k > 0; k--) begin m_v[k] = m_v[k-1]; m_t[k] = m_t[k-1]; end
                m_v[0] = iss_valid_i && (iss_addr_i != 0);
                m_t[0] = iss_addr_i;
            end
            if (flush_i) m_v[0] = 0;
        end
        @(negedge clk);
    endtask

    task automatic issue(input int unsigned a);
        idle();
        iss_valid_i = 1'b1;
        iss_addr_i  = AW'(a);
        cycle();
    endtask

    initial begin
        for (int k = 0; k < DP; k++) begin m_v[k] = 0; m_t[k] = 0; end
        m_cnt = 0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        idle();
        rd_addr_i = {AW'(5), AW'(3)};
        rf_data_i = {16'h1111, 16'h2222};
        #1;
        chk("reset_cnt", 32'(fwd_cnt_o), 32'h0);
        chk("reset_hit", 32'(fwd_hit_o), 32'h0);
        cycle();

        // Back-to-back ALU dependency
        issue(3);
        idle();
        rd_addr_i = {AW'(0), AW'(3)};
        stage_data_i[0 +: DW] = 16'h1234;
        #1;
        chk("alu_data", 32'(rd_data_o[0 +: DW]), 32'h1234);
        chk("alu_hit", 32'(fwd_hit_o[0]), 32'h1);
        chk("alu_stall", 32'(stall_req_o), 32'h0);
        cycle();

        // Load-use, then resolved from MEM
        issue(5);
        idle();
        rd_addr_i = {AW'(5), AW'(0)};
        rf_data_i = {16'hAAAA, 16'h0000};
        stage_rdy_i = 3'b110;
        #1;
        chk("lu_stall", 32'(stall_req_o), 32'h1);
        chk("lu_data", 32'(rd_data_o[DW +: DW]), 32'hAAAA);
        cycle();
        idle();
        rd_addr_i = {AW'(5), AW'(0)};
        stage_data_i[DW +: DW] = 16'hBEEF;
        #1;
        chk("lu_fwd", 32'(rd_data_o[DW +: DW]), 32'hBEEF);
        chk("lu_clear", 32'(stall_req_o), 32'h0);
        cycle();

        // Priority between stage 0 and stage 2
        issue(2);
        issue(8);
        issue(2);
        idle();
        rd_addr_i = {AW'(0), AW'(2)};
        rf_data_i = {16'h0000, 16'h5555};
        stage_data_i = {16'h0002, 16'h0077, 16'h0001};
        #1;
        chk("prio_data", 32'(rd_data_o[0 +: DW]), 32'h0001);
        stage_rdy_i = 3'b110;
        #1;
        chk("prio_stall", 32'(stall_req_o), 32'h1);
        chk("prio_nostale", 32'(rd_data_o[0 +: DW]), 32'h5555);
        cycle();

        // Register zero
        issue(0);
        idle();
        stage_data_i = {3{16'hFFFF}};
        #1;
        chk("r0_hit", 32'(fwd_hit_o), 32'h0);
        chk("r0_data", 32'(rd_data_o[0 +: DW]), 32'h0);
        cycle();

        // Flush of the issuing r7
        idle();
        iss_valid_i = 1'b1; iss_addr_i = AW'(7); flush_i = 1'b1;
        cycle();
        idle();
        rd_addr_i = {AW'(7), AW'(7)};
        #1;
        chk("flush_miss", 32'(fwd_hit_o), 32'h0);
        cycle();

        // Freeze holds r4 in stage 1
        issue(4);
        idle();
        cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); freeze_i = 1'b1; iss_valid_i = 1'b1; iss_addr_i = AW'(11);
            cycle();
        end
        idle();
        rd_addr_i = {AW'(0), AW'(4)};
        stage_data_i = {16'h0000, 16'h4444, 16'h0000};
        #1;
        chk("freeze_hold", 32'(rd_data_o[0 +: DW]), 32'h4444);
        cycle();

        // Flush together with freeze
        issue(6);
        issue(9);
        idle(); flush_i = 1'b1; freeze_i = 1'b1; iss_valid_i = 1'b1; iss_addr_i = AW'(10);
        cycle();
        idle();
        rd_addr_i = {AW'(6), AW'(9)};
        rf_data_i = {16'h6666, 16'h9999};
        stage_data_i = {16'h0000, 16'h000B, 16'h000A};
        #1;
        chk("ff_s0_clr", 32'(rd_data_o[0 +: DW]), 32'h9999);
        chk("ff_s1_held", 32'(rd_data_o[DW +: DW]), 32'h000B);
        cycle();

        // Reset mid-flight
        issue(1);
        issue(2);
        issue(3);
        idle(); rst = 1'b1;
        cycle();
        idle();
        rd_addr_i = {AW'(2), AW'(1)};
        #1;
        chk("rst_miss", 32'(fwd_hit_o), 32'h0);
        chk("rst_cnt0", 32'(fwd_cnt_o), 32'h0);
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 59) == 0);
            freeze_i     = ($urandom_range(0, 5) == 0);
            flush_i      = ($urandom_range(0, 7) == 0);
            iss_valid_i  = $urandom_range(0, 1);
            iss_addr_i   = AW'($urandom_range(0, 7));
            stage_rdy_i  = DP'($urandom);
            stage_data_i = {16'($urandom), 16'($urandom), 16'($urandom)};
            rd_addr_i    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            rf_data_i    = {16'($urandom), 16'($urandom)};
            cycle();
        end

        // Saturation: two hits per cycle until the counter pins
        for (int i = 0; i < 33000; i++) begin
            idle();
            iss_valid_i = 1'b1; iss_addr_i = AW'(1);
            rd_addr_i = {AW'(1), AW'(1)};
            stage_data_i = {16'h0003, 16'h0002, 16'h0001};
            cycle();
        end
        idle();
        #1;
        chk("sat_cnt", 32'(fwd_cnt_o), 32'hFFFF);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
